// File: rtl/disk_io_arbiter.sv
// Arbitrates NUM_CH block-storage clients onto the single SD image port:
// latched requests, round-robin grant, LBA setup before strobe, busy/done tracking with timeout.
module disk_io_arbiter #(
  parameter int unsigned NUM_CH = 4,
  parameter int unsigned LBA_W  = 32,
  parameter int unsigned LED_W  = 16,
  parameter int unsigned TMO_W  = 20
) (
  input  logic                      clk,
  input  logic                      _systemReset,
  input  logic [NUM_CH-1:0]         ch_rd,
  input  logic [NUM_CH-1:0]         ch_wr,
  input  logic [NUM_CH*LBA_W-1:0]   ch_lba,
  input  logic [NUM_CH-1:0]         ch_wprot,
  input  logic [NUM_CH*8-1:0]       ch_dout,
  output logic [NUM_CH-1:0]         ch_ack,
  output logic [NUM_CH-1:0]         ch_err,
  output logic [NUM_CH-1:0]         ch_led,
  output logic [NUM_CH-1:0]         sdc_rd,
  output logic [NUM_CH-1:0]         sdc_wr,
  output logic [31:0]               sdc_lba,
  output logic [7:0]                sdc_data_out,
  input  logic                      sdc_busy,
  input  logic                      sdc_done
);

  localparam int unsigned GW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    SETUP     = 3'd1,
    ISSUE     = 3'd2,
    WAIT_BUSY = 3'd3,
    WAIT_DONE = 3'd4,
    DONE      = 3'd5
  } state_t;

  state_t            state_q, state_d;
  logic [NUM_CH-1:0] pend_rd_q, pend_rd_d, pend_wr_q, pend_wr_d;
  logic [GW-1:0]     grant_q, grant_d, rr_q, rr_d;
  logic              op_rd_q, op_rd_d;
  logic [31:0]       lba_q, lba_d;
  logic [TMO_W-1:0]  tmo_q, tmo_d;
  logic [NUM_CH-1:0] ack_q, ack_d, err_q, err_d, rd_q, rd_d, wr_q, wr_d, led_q, led_d;
  logic [LED_W-1:0]  led_cnt_q [NUM_CH];
  logic [LED_W-1:0]  led_cnt_d [NUM_CH];

  logic [GW-1:0]     pick, idx;
  logic              found;
  logic [NUM_CH-1:0] pend_any, gnt_oh, pick_oh, wp_hit, led_reload, clr_rd, clr_wr;
  logic [LBA_W-1:0]  lba_pick;
  logic [7:0]        dout_sel;

  assign pend_any   = pend_rd_q | pend_wr_q;
  assign gnt_oh     = NUM_CH'(1) << grant_q;
  assign pick_oh    = NUM_CH'(1) << pick;
  // A same-cycle read swallows the write, including a protected one.
  assign wp_hit     = ch_wr & ch_wprot & ~ch_rd;
  assign led_reload = wp_hit | ((state_q == SETUP) ? gnt_oh : '0);

  // Round-robin search starting at rr_q, wrapping.
  always_comb begin
    pick  = rr_q;
    idx   = '0;
    found = 1'b0;
    for (int unsigned k = 0; k < NUM_CH; k++) begin
      idx = GW'((32'(rr_q) + k) % NUM_CH);
      if (!found && pend_any[idx]) begin
        pick  = idx;
        found = 1'b1;
      end
    end
  end

  // Per-channel muxes for the candidate LBA and the granted write byte.
  always_comb begin
    lba_pick = '0;
    dout_sel = '0;
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      if (GW'(i) == pick)    lba_pick = ch_lba[i*LBA_W +: LBA_W];
      if (GW'(i) == grant_q) dout_sel = ch_dout[i*8 +: 8];
    end
  end

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    op_rd_d = op_rd_q;
    lba_d   = lba_q;
    rr_d    = rr_q;
    tmo_d   = tmo_q;
    clr_rd  = '0;
    clr_wr  = '0;
    err_d   = '0;
    unique case (state_q)
      IDLE: begin
        if (|pend_any) begin
          grant_d = pick;
          op_rd_d = pend_rd_q[pick];
          lba_d   = 32'(lba_pick);
          if (pend_rd_q[pick]) clr_rd = pick_oh;
          else                 clr_wr = pick_oh;
          state_d = SETUP;
        end
      end
      SETUP: state_d = ISSUE;
      ISSUE: begin
        tmo_d   = '0;
        state_d = WAIT_BUSY;
      end
      WAIT_BUSY: begin
        if (sdc_busy)      state_d = WAIT_DONE;
        else if (sdc_done) state_d = DONE;
        else if (&tmo_q) begin
          err_d   = gnt_oh;
          state_d = DONE;
        end else begin
          tmo_d = tmo_q + TMO_W'(1);
        end
      end
      WAIT_DONE: if (!sdc_busy || sdc_done) state_d = DONE;
      DONE: begin
        rr_d    = (grant_q == GW'(NUM_CH - 1)) ? '0 : grant_q + GW'(1);
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // Set after clear so a strobe on the channel just granted re-latches.
    pend_rd_d = (pend_rd_q & ~clr_rd) | ch_rd;
    pend_wr_d = (pend_wr_q & ~clr_wr) | (ch_wr & ~ch_wprot & ~ch_rd);

    rd_d  = (state_q == SETUP &&  op_rd_q) ? gnt_oh : '0;
    wr_d  = (state_q == SETUP && !op_rd_q) ? gnt_oh : '0;
    ack_d = wp_hit |
            ((state_d inside {ISSUE, WAIT_BUSY, WAIT_DONE, DONE}) ? gnt_oh : '0);
  end

  // Saturating LED stretch counters.
  always_comb begin
    led_cnt_d = led_cnt_q;
    led_d     = '0;
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      if (led_reload[i])             led_cnt_d[i] = '1;
      else if (led_cnt_q[i] != '0)   led_cnt_d[i] = led_cnt_q[i] - LED_W'(1);
      led_d[i] = (led_cnt_d[i] != '0);
    end
  end

  always_ff @(posedge clk or negedge _systemReset) begin
    if (!_systemReset) begin
      state_q   <= IDLE;
      pend_rd_q <= '0;
      pend_wr_q <= '0;
      grant_q   <= '0;
      rr_q      <= '0;
      op_rd_q   <= 1'b0;
      lba_q     <= '0;
      tmo_q     <= '0;
      ack_q     <= '0;
      err_q     <= '0;
      rd_q      <= '0;
      wr_q      <= '0;
      led_q     <= '0;
      for (int unsigned i = 0; i < NUM_CH; i++) led_cnt_q[i] <= '0;
    end else begin
      state_q   <= state_d;
      pend_rd_q <= pend_rd_d;
      pend_wr_q <= pend_wr_d;
      grant_q   <= grant_d;
      rr_q      <= rr_d;
      op_rd_q   <= op_rd_d;
      lba_q     <= lba_d;
      tmo_q     <= tmo_d;
      ack_q     <= ack_d;
      err_q     <= err_d;
      rd_q      <= rd_d;
      wr_q      <= wr_d;
      led_q     <= led_d;
      led_cnt_q <= led_cnt_d;
    end
  end

  assign ch_ack       = ack_q;
  assign ch_err       = err_q;
  assign ch_led       = led_q;
  assign sdc_rd       = rd_q;
  assign sdc_wr       = wr_q;
  assign sdc_lba      = lba_q;
  assign sdc_data_out = dout_sel;

endmodule

// File: tb/tb_disk_io_arbiter.sv
// Scoreboard bench for disk_io_arbiter: a transaction-level model predicts service order,
// an SD-side responder answers strobes, and a monitor checks every issued operation.
module tb_disk_io_arbiter;

  localparam int unsigned NUM_CH = 4;
  localparam int unsigned LBA_W  = 32;
  localparam int unsigned LED_W  = 6;
  localparam int unsigned TMO_W  = 4;

  typedef struct {
    int          ch;
    bit          rd;
    logic [31:0] lba;
    logic [7:0]  data;
  } exp_t;

  logic                    clk = 1'b0;
  logic                    sys_rst_n;
  logic [NUM_CH-1:0]       ch_rd, ch_wr, ch_wprot;
  logic [NUM_CH*LBA_W-1:0] ch_lba;
  logic [NUM_CH*8-1:0]     ch_dout;
  logic [NUM_CH-1:0]       ch_ack, ch_err, ch_led, sdc_rd, sdc_wr;
  logic [31:0]             sdc_lba;
  logic [7:0]              sdc_data_out;
  logic                    sdc_busy, sdc_done;

  int checks   = 0;
  int failures = 0;

  exp_t        exp_q[$];
  bit          err_exp_q[$];
  logic [31:0] lba_arr [NUM_CH];
  logic [7:0]  dout_arr [NUM_CH];
  int          rr_m;
  int          force_mode, force_d, force_l;
  bit          mon_busy, resp_busy;

  disk_io_arbiter #(
    .NUM_CH(NUM_CH), .LBA_W(LBA_W), .LED_W(LED_W), .TMO_W(TMO_W)
  ) dut (
    .clk          (clk),
    ._systemReset (sys_rst_n),
    .ch_rd        (ch_rd),
    .ch_wr        (ch_wr),
    .ch_lba       (ch_lba),
    .ch_wprot     (ch_wprot),
    .ch_dout      (ch_dout),
    .ch_ack       (ch_ack),
    .ch_err       (ch_err),
    .ch_led       (ch_led),
    .sdc_rd       (sdc_rd),
    .sdc_wr       (sdc_wr),
    .sdc_lba      (sdc_lba),
    .sdc_data_out (sdc_data_out),
    .sdc_busy     (sdc_busy),
    .sdc_done     (sdc_done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic pack();
    for (int i = 0; i < NUM_CH; i++) begin
      ch_lba[i*LBA_W +: LBA_W] = lba_arr[i];
      ch_dout[i*8 +: 8]        = dout_arr[i];
    end
  endtask

  // Reference model: one served op on channel ch moves the pointer past it.
  task automatic push_exp(input int ch, input bit rd);
    exp_t e;
    e.ch   = ch;
    e.rd   = rd;
    e.lba  = lba_arr[ch];
    e.data = dout_arr[ch];
    exp_q.push_back(e);
    rr_m = (ch + 1) % NUM_CH;
  endtask

  // All strobes in one cycle while idle: served in round-robin order from the model pointer.
  task automatic issue_batch(input logic [3:0] rd, input logic [3:0] wr, input logic [3:0] wp);
    logic [3:0] wpexp;
    int start, i;
    for (int c = 0; c < NUM_CH; c++) begin
      lba_arr[c]  = $urandom;
      dout_arr[c] = 8'($urandom);
    end
    pack();
    ch_wprot = wp;
    start = rr_m;
    for (int k = 0; k < NUM_CH; k++) begin
      i = (start + k) % NUM_CH;
      if (rd[i])               push_exp(i, 1'b1);
      else if (wr[i] && !wp[i]) push_exp(i, 1'b0);
    end
    wpexp = wr & wp & ~rd;
    @(posedge clk); #1;
    ch_rd = rd;
    ch_wr = wr;
    @(negedge clk);
    @(posedge clk); #1;
    ch_rd = '0;
    ch_wr = '0;
    @(negedge clk);
    chk("wp_ack_pulse", ch_ack, wpexp);
    chk("wp_led_on", ch_led & wpexp, wpexp);
    @(negedge clk);
    chk("wp_ack_end", ch_ack, 4'b0);
  endtask

  task automatic wait_idle();
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(exp_q.size() == 0 && !mon_busy && !resp_busy && ch_ack == '0) && n < 3000);
    if (n >= 3000) begin
      checks++;
      failures++;
      $display("FAIL idle_wait: pending=%0d ack=0x%0h", exp_q.size(), ch_ack);
    end
    repeat (2) @(negedge clk);
  endtask

  // SD-side responder: busy window, done pulse, silence (timeout) or a long busy.
  initial begin : responder
    int mode, d, l, r;
    sdc_busy  = 1'b0;
    sdc_done  = 1'b0;
    resp_busy = 1'b0;
    forever begin
      @(negedge clk);
      if (sys_rst_n && (sdc_rd | sdc_wr) != '0) begin
        resp_busy = 1'b1;
        if (force_mode >= 0) mode = force_mode;
        else begin
          r    = int'($urandom_range(0, 5));
          mode = (r < 3) ? 0 : (r < 5) ? 1 : 2;
        end
        d = (force_d >= 0) ? force_d : int'($urandom_range(0, 3));
        l = (force_l >= 0) ? force_l : int'($urandom_range(1, 6));
        err_exp_q.push_back(mode == 2);
        @(posedge clk); #1;
        repeat (d) begin @(posedge clk); #1; end
        case (mode)
          0: begin
            sdc_busy = 1'b1;
            repeat (l) begin @(posedge clk); #1; end
            sdc_busy = 1'b0;
          end
          1: begin
            sdc_done = 1'b1;
            @(posedge clk); #1;
            sdc_done = 1'b0;
          end
          3: begin
            sdc_busy = 1'b1;
            repeat (30) begin @(posedge clk); #1; end
            sdc_busy = 1'b0;
          end
          default: ;
        endcase
        resp_busy = 1'b0;
      end
    end
  end

  // Monitor: pops the scoreboard on each SD strobe and follows the op to completion.
  initial begin : monitor
    exp_t       e;
    logic [3:0] strb, oh;
    int         g, errs, n;
    bit         eerr;
    mon_busy = 1'b0;
    forever begin
      @(negedge clk);
      strb = sdc_rd | sdc_wr;
      if (sys_rst_n && strb != '0) begin
        mon_busy = 1'b1;
        g = 0;
        for (int i = NUM_CH - 1; i >= 0; i--) if (strb[i]) g = i;
        if (exp_q.size() == 0) chk("unexpected_op", strb, 4'b0);
        else begin
          e  = exp_q.pop_front();
          oh = 4'(1) << e.ch;
          chk("op_rd", sdc_rd, e.rd ? oh : 4'b0);
          chk("op_wr", sdc_wr, e.rd ? 4'b0 : oh);
          chk("op_lba", sdc_lba, e.lba);
          chk("op_data", sdc_data_out, e.data);
          chk("op_ack", ch_ack, oh);
        end
        @(negedge clk);
        chk("strobe_width", sdc_rd | sdc_wr, 4'b0);
        errs = 0;
        n    = 0;
        while (sys_rst_n && ch_ack[g] && n < 100) begin
          errs += $countones(ch_err);
          n++;
          @(negedge clk);
        end
        if (n >= 100) begin
          checks++;
          failures++;
          $display("FAIL op_complete: ch=%0d ack stuck high", g);
        end
        eerr = (err_exp_q.size() != 0) ? err_exp_q.pop_front() : 1'b0;
        chk("op_err_pulses", errs, eerr ? 1 : 0);
        mon_busy = 1'b0;
      end
    end
  end

  initial begin : watchdog
    #400000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog expired");
  end

  initial begin : stimulus
    int         n, led_n;
    logic [3:0] wr_seen, rd, wr, wp;

    sys_rst_n  = 1'b0;
    ch_rd      = '0;
    ch_wr      = '0;
    ch_wprot   = '0;
    force_mode = -1;
    force_d    = -1;
    force_l    = -1;
    rr_m       = 0;
    for (int i = 0; i < NUM_CH; i++) begin
      lba_arr[i]  = $urandom;
      dout_arr[i] = 8'($urandom);
    end
    pack();

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ack", ch_ack, 4'b0);
    chk("rst_err", ch_err, 4'b0);
    chk("rst_led", ch_led, 4'b0);
    chk("rst_sdc_rd", sdc_rd, 4'b0);
    chk("rst_sdc_wr", sdc_wr, 4'b0);
    chk("rst_sdc_lba", sdc_lba, 32'h0);
    sys_rst_n = 1'b1;
    @(negedge clk);

    // Protected write: one-cycle ack, LED stretched for 2^LED_W-1 cycles, never forwarded
    ch_wprot = 4'b0010;
    @(posedge clk); #1;
    ch_wr = 4'b0010;
    @(negedge clk);
    chk("wp_led_c0", ch_led, 4'b0);
    @(posedge clk); #1;
    ch_wr = '0;
    @(negedge clk);
    chk("wp_ack_c1", ch_ack, 4'b0010);
    led_n   = ch_led[1] ? 1 : 0;
    wr_seen = sdc_wr;
    @(negedge clk);
    chk("wp_ack_c2", ch_ack, 4'b0);
    while (ch_led[1] && led_n < 200) begin
      led_n++;
      wr_seen |= sdc_wr;
      @(negedge clk);
    end
    chk("wp_led_stretch", led_n, (1 << LED_W) - 1);
    chk("wp_no_sdc_wr", wr_seen, 4'b0);
    ch_wprot = '0;
    wait_idle();

    // Single read on ch2: LBA at cycle 2, strobe only at cycle 3, ack until 1 cycle after busy falls
    lba_arr[2]  = 32'h1234;
    dout_arr[2] = 8'h5A;
    pack();
    push_exp(2, 1'b1);
    force_mode = 0;
    force_d    = 1;
    force_l    = 5;
    @(posedge clk); #1;
    ch_rd = 4'b0100;
    @(negedge clk);
    @(posedge clk); #1;
    ch_rd = '0;
    @(negedge clk);
    chk("rd_ack_c1", ch_ack, 4'b0);
    @(negedge clk);
    chk("rd_lba_c2", sdc_lba, 32'h1234);
    chk("rd_strobe_c2", sdc_rd, 4'b0);
    @(negedge clk);
    chk("rd_strobe_c3", sdc_rd, 4'b0100);
    @(negedge clk);
    chk("rd_strobe_c4", sdc_rd, 4'b0);
    chk("rd_ack_c4", ch_ack, 4'b0100);
    repeat (7) @(negedge clk);
    chk("rd_ack_c11", ch_ack, 4'b0100);
    @(negedge clk);
    chk("rd_ack_c12", ch_ack, 4'b0);
    wait_idle();
    force_mode = -1;
    force_d    = -1;
    force_l    = -1;

    // Read+write collision on ch3: read only
    issue_batch(4'b1000, 4'b1000, 4'b0000);
    wait_idle();

    // Timeout on two queued channels: each errs once, the second is still served
    force_mode = 2;
    issue_batch(4'b0011, 4'b0000, 4'b0000);
    wait_idle();
    force_mode = -1;

    // Round robin from a fresh reset with ch0 re-requested during op 1
    @(posedge clk); #1;
    sys_rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    sys_rst_n = 1'b1;
    rr_m = 0;
    force_mode = 0;
    force_d    = 0;
    force_l    = 5;
    issue_batch(4'b1111, 4'b0000, 4'b0000);
    n = 0;
    while (sdc_rd != 4'b0010 && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) begin
      checks++;
      failures++;
      $display("FAIL rr_op1_wait: sdc_rd=0x%0h", sdc_rd);
    end
    push_exp(0, 1'b1);
    @(posedge clk); #1;
    ch_rd = 4'b0001;
    @(posedge clk); #1;
    ch_rd = '0;
    wait_idle();

    // Reset while waiting for done: outputs clear asynchronously, then normal service resumes
    force_mode = 3;
    force_d    = 0;
    issue_batch(4'b0010, 4'b0000, 4'b0000);
    n = 0;
    while (sdc_rd == '0 && n < 50) begin
      @(negedge clk);
      n++;
    end
    repeat (2) @(negedge clk);
    #2;
    sys_rst_n = 1'b0;
    #1;
    chk("arst_ack", ch_ack, 4'b0);
    chk("arst_err", ch_err, 4'b0);
    chk("arst_led", ch_led, 4'b0);
    chk("arst_sdc_rd", sdc_rd, 4'b0);
    chk("arst_sdc_wr", sdc_wr, 4'b0);
    chk("arst_sdc_lba", sdc_lba, 32'h0);
    repeat (2) @(posedge clk);
    #1;
    sys_rst_n = 1'b1;
    rr_m = 0;
    @(negedge clk);
    chk("post_rst_led", ch_led, 4'b0);
    chk("post_rst_ack", ch_ack, 4'b0);
    wait_idle();
    force_mode = -1;
    force_d    = -1;
    force_l    = -1;
    issue_batch(4'b0001, 4'b0000, 4'b0000);
    wait_idle();

    // Randomized batches
    for (int b = 0; b < 30; b++) begin
      rd = 4'($urandom);
      wr = 4'($urandom);
      wp = 4'($urandom & $urandom);
      if (b % 5 == 0) rd = '0;
      issue_batch(rd, wr, wp);
      wait_idle();
    end

    chk("scoreboard_drained", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
